// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (signed/unsigned) answering the EX-stage start/ready handshake.
// Latency: ready_o is high WIDTH+1 edges after start is accepted, or one edge for a zero divisor; result is held until start_i drops.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_DIVZERO = 2'b01,
    S_ON      = 2'b10,
    S_END     = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]     r_divisor;
  logic                 r_signed;
  logic                 r_neg1;
  logic                 r_neg2;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;

  logic                 w_accept;
  logic                 w_steps_done;
  logic [WIDTH-1:0]     w_mag1;
  logic [WIDTH-1:0]     w_mag2;
  logic [WIDTH:0]       w_upper;
  logic [WIDTH:0]       w_trial;
  logic                 w_sub_ok;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [2*WIDTH-1:0]   w_result_nxt;
  logic                 w_ready_nxt;

  assign w_accept     = start_i && !annul_i;
  assign w_steps_done = (r_cnt == CW'(WIDTH));

  always_comb begin
    w_mag1 = opdata1_i;
    w_mag2 = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) w_mag1 = -opdata1_i;
    if (signed_div_i && opdata2_i[WIDTH-1]) w_mag2 = -opdata2_i;
  end

  // Upper WIDTH+1 bits of the working register after the left shift; the shifted-in bit is the new quotient bit.
  assign w_upper  = r_work[2*WIDTH-1:WIDTH-1];
  assign w_trial  = w_upper - {1'b0, r_divisor};
  assign w_sub_ok = ~w_trial[WIDTH];

  always_comb begin
    w_quo = r_work[WIDTH-1:0];
    w_rem = r_work[2*WIDTH-1:WIDTH];
    if (r_signed && (r_neg1 ^ r_neg2)) w_quo = -r_work[WIDTH-1:0];
    if (r_signed && r_neg1)            w_rem = -r_work[2*WIDTH-1:WIDTH];
  end

  // State register, with the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = (opdata2_i == '0) ? S_DIVZERO : S_ON;
      end
      S_DIVZERO: begin
        w_state_nxt = annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        if (annul_i)           w_state_nxt = S_IDLE;
        else if (w_steps_done) w_state_nxt = S_END;
      end
      S_END: begin
        if (!start_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_ready_nxt  = (w_state_nxt == S_END);
    w_result_nxt = '0;
    if (r_state == S_ON && w_steps_done && !annul_i)
      w_result_nxt = {w_rem, w_quo};
    else if (r_state == S_END && start_i)
      w_result_nxt = r_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_accept && opdata2_i != '0) begin
        r_cnt     <= '0;
        r_work    <= {{WIDTH{1'b0}}, w_mag1};
        r_divisor <= w_mag2;
        r_signed  <= signed_div_i;
        r_neg1    <= signed_div_i & opdata1_i[WIDTH-1];
        r_neg2    <= signed_div_i & opdata2_i[WIDTH-1];
      end else if (r_state == S_ON && !annul_i && !w_steps_done) begin
        r_work <= {(w_sub_ok ? w_trial[WIDTH-1:0] : w_upper[WIDTH-1:0]),
                   r_work[WIDTH-2:0], w_sub_ok};
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_iter.sv
// Directed-vector bench for div_iter: latency, results, hold/release, annul and mid-divide reset.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_tests = 0;
  int n_fail  = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation, wait for ready, check latency/result/hold, then release.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    int early;
    @(negedge clk);
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    early = 0;
    while (!ready && n < 100) begin
      if (result !== 64'd0) early++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " result"}, result, exp);
    check({tag, " early result"}, 64'(early), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " held result"}, result, exp);
    check({tag, " held ready"}, {63'd0, ready}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, " release ready"}, {63'd0, ready}, 64'd0);
    check({tag, " release result"}, result, 64'd0);
  endtask

  initial begin
    int highs;
    rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div("u 100/7",      1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);
    do_div("s -7/2",       1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33);
    do_div("s 7/-2",       1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33);
    do_div("s min/-1",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33);
    do_div("u max/1",      1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 33);
    do_div("u 5/9",        1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 33);
    do_div("u div0",       1'b0, 32'd1234,       32'd0,          64'd0,                 1);
    do_div("s div0",       1'b1, 32'hFFFFFF00,   32'd0,          64'd0,                 1);
    do_div("u 1000/10",    1'b0, 32'd1000,       32'd10,         64'h00000000_00000064, 33);

    // Annul on the E10 edge.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready) highs++;
    end
    check("annul ready stays low", 64'(highs), 64'd0);
    do_div("u 20/3 after annul", 1'b0, 32'd20, 32'd3, 64'h00000002_00000006, 33);

    // Synchronous reset mid-divide, after E15.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid reset ready", {63'd0, ready}, 64'd0);
    check("mid reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready) highs++;
    end
    check("post reset idle", 64'(highs), 64'd0);
    do_div("u 9/3 after reset", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
